// File: rtl/sync_down_cntr.sv
// Synchronous down counter with load, terminal count and expiry pulse.
// Define SYNC_DOWN_CNTR_RELOAD_EN for free-running reload instead of one-shot halt.
module sync_down_cntr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  localparam logic [0:0] StCount = 1'b0;
  localparam logic [0:0] StHalt  = 1'b1;

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cnt_zero;
  logic             expire;

`ifdef SYNC_DOWN_CNTR_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign tc       = (state_q == StCount) && en && cnt_zero;
  // tc may be high while load is asserted; only an unloaded tc counts as expiry.
  assign expire   = tc && !load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SYNC_DOWN_CNTR_RELOAD_EN
    reload_d = reload_q;
`endif

    if (clear) begin
      state_d = StCount;
      cnt_d   = AllOnes;
      busy_d  = 1'b1;
`ifdef SYNC_DOWN_CNTR_RELOAD_EN
      reload_d = AllOnes;
`endif
    end else if (load) begin
      state_d = StCount;
      cnt_d   = load_val;
      busy_d  = 1'b1;
`ifdef SYNC_DOWN_CNTR_RELOAD_EN
      reload_d = load_val;
`endif
    end else if (expire) begin
      done_d = 1'b1;
`ifdef SYNC_DOWN_CNTR_RELOAD_EN
      cnt_d   = reload_q;
      state_d = StCount;
      busy_d  = 1'b1;
`else
      cnt_d   = '0;
      state_d = StHalt;
      busy_d  = 1'b0;
`endif
    end else if ((state_q == StCount) && en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StCount;
      cnt_q   <= AllOnes;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SYNC_DOWN_CNTR_RELOAD_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      reload_q <= AllOnes;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign q    = cnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sync_down_cntr.sv
// Directed self-checking bench for sync_down_cntr at WIDTH=3.
module tb_sync_down_cntr;

  logic       clk;
  logic       clear;
  logic       en;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] q;
  logic       tc;
  logic       done;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef SYNC_DOWN_CNTR_RELOAD_EN
  localparam bit Reload = 1'b1;
`else
  localparam bit Reload = 1'b0;
`endif

  sync_down_cntr #(
    .WIDTH(3)
  ) u_dut (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .tc      (tc),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] eq, input logic ed,
                           input logic eb);
    check_val({tag, ".q"}, q, eq);
    check_val({tag, ".done"}, done, ed);
    check_val({tag, ".busy"}, busy, eb);
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; load = 1'b0; load_val = 3'd0;

    // 1: reset then full count-down from 7
    tick(); tick();
    chk_state("rst", 3'd7, 1'b0, 1'b1);
    check_val("rst.tc", tc, 1'b0);
    clear = 1'b0; en = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      tick();
      check_val("t1.q", q, i);
      check_val("t1.tc", tc, (i == 0));
    end
    tick();
    chk_state("t1.exp", Reload ? 3'd7 : 3'd0, 1'b1, Reload);
    en = 1'b0;
    tick();
    chk_state("t1.post", Reload ? 3'd7 : 3'd0, 1'b0, Reload);

    // 3: HALT ignores en; load restarts
    if (!Reload) begin
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk_state("t3.halt", 3'd0, 1'b0, 1'b0);
        check_val("t3.tc", tc, 1'b0);
      end
      load = 1'b1; load_val = 3'd5;
      tick();
      load = 1'b0;
      chk_state("t3.load", 3'd5, 1'b0, 1'b1);
      tick();
      check_val("t3.resume", q, 3'd4);
    end

    // 2: load with en, load wins
    load = 1'b1; load_val = 3'd3; en = 1'b1;
    tick();
    load = 1'b0;
    chk_state("t2.load", 3'd3, 1'b0, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      tick();
      check_val("t2.q", q, i);
    end
    check_val("t2.tc", tc, 1'b1);
    tick();
    chk_state("t2.exp", Reload ? 3'd3 : 3'd0, 1'b1, Reload);

    // 4: en gap holds count
    load = 1'b1; load_val = 3'd4;
    tick();
    load = 1'b0;
    tick(); tick();
    check_val("t4.q2", q, 3'd2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("t4.hold", 3'd2, 1'b0, 1'b1);
      check_val("t4.tc", tc, 1'b0);
    end
    en = 1'b1;
    tick(); check_val("t4.q1", q, 3'd1);
    tick(); check_val("t4.q0", q, 3'd0);
    check_val("t4.tc0", tc, 1'b1);
    tick();
    check_val("t4.done", done, 1'b1);

    // 5: load in the same cycle as tc
    load = 1'b1; load_val = 3'd1;
    tick();
    load = 1'b0;
    tick();
    check_val("t5.q0", q, 3'd0);
    load = 1'b1; load_val = 3'd6;
    #1 check_val("t5.tc", tc, 1'b1);
    tick();
    load = 1'b0;
    chk_state("t5.load", 3'd6, 1'b0, 1'b1);
    tick();
    chk_state("t5.next", 3'd5, 1'b0, 1'b1);

    // 6: clear mid-count, at expiry edge, and after expiry
    load = 1'b1; load_val = 3'd6;
    tick();
    load = 1'b0;
    tick(); tick();
    check_val("t6.q4", q, 3'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_state("t6.mid", 3'd7, 1'b0, 1'b1);
    load = 1'b1; load_val = 3'd0;
    tick();
    load = 1'b0;
    check_val("t6.tc", tc, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_state("t6.atexp", 3'd7, 1'b0, 1'b1);
    load = 1'b1; load_val = 3'd0;
    tick();
    load = 1'b0;
    tick();
    chk_state("t6.exp", 3'd0, 1'b1, Reload);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_state("t6.aft", 3'd7, 1'b0, 1'b1);

    // 7: reload of zero expires every enabled cycle
    if (Reload) begin
      load = 1'b1; load_val = 3'd0;
      tick();
      load = 1'b0;
      chk_state("t7.load", 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
        check_val("t7.tc", tc, 1'b1);
        tick();
        chk_state("t7.run", 3'd0, 1'b1, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
